// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle MIPS control FSM with memory wait-state handshake,
//               memory timeout exception and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm #(
    parameter int TIMEOUT_W  = 4,
    parameter int TIMEOUT_EN = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_wr_cond,
    output logic             pc_wr_cond_ne,
    output logic             pc_wr,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       mem_to_reg,
    output logic             ir_wr,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             alu_src_a,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic             exc,
    output logic [1:0]       exc_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB_LOAD   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_WB_R      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JR        = 4'd10,
        S_JAL       = 4'd11,
        S_EXEC_I    = 4'd12,
        S_WB_I      = 4'd13,
        S_EXC       = 4'd14
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_timeout = 2'b10;

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]       retired_q, retired_d;
    logic                   exc_q, exc_d;
    logic [1:0]             exc_cause_q, exc_cause_d;
    logic [1:0]             new_cause;
    logic                   timeout;
    logic                   in_wait_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            retired_q   <= '0;
            exc_q       <= 1'b0;
            exc_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            retired_q   <= retired_d;
            exc_q       <= exc_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        retired_d     = retired_q;
        exc_d         = exc_q;
        exc_cause_d   = exc_cause_q;
        new_cause     = c_cause_illegal;
        pc_wr_cond    = 1'b0;
        pc_wr_cond_ne = 1'b0;
        pc_wr         = 1'b0;
        iord          = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_to_reg    = 2'b00;
        ir_wr         = 1'b0;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        alu_src_a     = 1'b0;
        reg_wr        = 1'b0;
        reg_dst       = 2'b00;
        in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
        timeout       = (TIMEOUT_EN != 0) && !mem_ready && (wait_cnt_q == '1);

        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_EXC;
                    new_cause = c_cause_timeout;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    c_op_rtype:       state_d = (funct == c_fn_jr) ? S_JR : S_EXEC_R;
                    c_op_lw, c_op_sw: state_d = S_MEM_ADDR;
                    c_op_beq, c_op_bne: state_d = S_BRANCH;
                    c_op_j:           state_d = S_JUMP;
                    c_op_jal:         state_d = S_JAL;
                    c_op_addi:        state_d = S_EXEC_I;
                    default:          state_d = S_EXC;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_LOAD;
                end else if (timeout) begin
                    state_d   = S_EXC;
                    new_cause = c_cause_timeout;
                end
            end
            S_WB_LOAD: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d   = S_EXC;
                    new_cause = c_cause_timeout;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = 2'b01;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_src        = 2'b01;
                pc_wr_cond    = (op == c_op_beq);
                pc_wr_cond_ne = (op == c_op_bne);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_wr   = 1'b1;
                pc_src  = 2'b10;
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_wr   = 1'b1;
                pc_src  = 2'b11;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link value is written as the PC reloads.
                reg_wr     = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_wr      = 1'b1;
                pc_src     = 2'b10;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXC: begin
                state_d = S_EXC;
            end
            default: begin
                state_d = S_EXC;
            end
        endcase

        if ((state_d == S_EXC) && (state_q != S_EXC)) begin
            exc_d = 1'b1;
            if (!exc_q) begin
                exc_cause_d = new_cause;
            end
        end

        if (in_wait_state && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            retired_d = retired_q + CNT_W'(1);
        end

        if (rst) begin
            pc_wr_cond    = 1'b0;
            pc_wr_cond_ne = 1'b0;
            pc_wr         = 1'b0;
            iord          = 1'b0;
            mem_rd        = 1'b0;
            mem_wr        = 1'b0;
            mem_to_reg    = 2'b00;
            ir_wr         = 1'b0;
            pc_src        = 2'b00;
            alu_op        = 2'b00;
            alu_src_b     = 2'b00;
            alu_src_a     = 1'b0;
            reg_wr        = 1'b0;
            reg_dst       = 2'b00;
        end
    end

    assign exc       = exc_q;
    assign exc_cause = exc_cause_q;
    assign state_o   = state_q;
    assign retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm, plus hand sequences for
// timeout, exception stickiness and asynchronous reset corners.
`default_nettype none

module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mem_ready;

    logic        pc_wr_cond, pc_wr_cond_ne, pc_wr, iord, mem_rd, mem_wr, ir_wr;
    logic        alu_src_a, reg_wr, exc;
    logic [1:0]  mem_to_reg, pc_src, alu_op, alu_src_b, reg_dst, exc_cause;
    logic [3:0]  state_o;
    logic [31:0] retired;

    logic        d2_pcc, d2_pcne, d2_pcw, d2_iord, d2_mrd, d2_mwr, d2_irw;
    logic        d2_asrc, d2_rw, d2_exc;
    logic [1:0]  d2_m2r, d2_psrc, d2_aop, d2_bsrc, d2_rdst, d2_cause;
    logic [3:0]  d2_state;
    logic [31:0] d2_retired;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_wr_cond(pc_wr_cond), .pc_wr_cond_ne(pc_wr_cond_ne), .pc_wr(pc_wr),
        .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
        .ir_wr(ir_wr), .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .alu_src_a(alu_src_a), .reg_wr(reg_wr), .reg_dst(reg_dst), .exc(exc),
        .exc_cause(exc_cause), .state_o(state_o), .retired(retired)
    );

    mc_ctrl_fsm #(.TIMEOUT_EN(0)) dut_nto (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_wr_cond(d2_pcc), .pc_wr_cond_ne(d2_pcne), .pc_wr(d2_pcw),
        .iord(d2_iord), .mem_rd(d2_mrd), .mem_wr(d2_mwr), .mem_to_reg(d2_m2r),
        .ir_wr(d2_irw), .pc_src(d2_psrc), .alu_op(d2_aop), .alu_src_b(d2_bsrc),
        .alu_src_a(d2_asrc), .reg_wr(d2_rw), .reg_dst(d2_rdst), .exc(d2_exc),
        .exc_cause(d2_cause), .state_o(d2_state), .retired(d2_retired)
    );

    logic [18:0] ctl;
    assign ctl = {pc_wr_cond, pc_wr_cond_ne, pc_wr, iord, mem_rd, mem_wr, mem_to_reg,
                  ir_wr, pc_src, alu_op, alu_src_b, alu_src_a, reg_wr, reg_dst};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic logic [18:0] cw(input logic pcc, input logic pcne, input logic pcw,
                                       input logic io, input logic mrd, input logic mwr,
                                       input logic [1:0] m2r, input logic irw,
                                       input logic [1:0] psrc, input logic [1:0] aop,
                                       input logic [1:0] bsrc, input logic asrc,
                                       input logic rw, input logic [1:0] rdst);
        return {pcc, pcne, pcw, io, mrd, mwr, m2r, irw, psrc, aop, bsrc, asrc, rw, rdst};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic r,
                       input logic [3:0] s, input logic [18:0] c, input logic e,
                       input logic [1:0] ca, input logic [31:0] rt);
        vec_t v;
        v.op = o; v.fn = f; v.rdy = r; v.st = s; v.ctl = c; v.exc = e; v.cause = ca; v.ret = rt;
        vecs.push_back(v);
    endtask

    logic [18:0] F_NR, F_RDY, DEC, MADR, MRD, WBL, MWR, EXR, WBR;
    logic [18:0] BEQ, BNE, JMP, JRC, JALC, EXI, WBI, ZERO;
    int cyc;

    initial begin
        F_NR  = cw(0,0,0,0,1,0,2'b00,0,2'b00,2'b00,2'b01,0,0,2'b00);
        F_RDY = cw(0,0,1,0,1,0,2'b00,1,2'b00,2'b00,2'b01,0,0,2'b00);
        DEC   = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b11,0,0,2'b00);
        MADR  = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b10,1,0,2'b00);
        MRD   = cw(0,0,0,1,1,0,2'b00,0,2'b00,2'b00,2'b00,0,0,2'b00);
        WBL   = cw(0,0,0,0,0,0,2'b01,0,2'b00,2'b00,2'b00,0,1,2'b00);
        MWR   = cw(0,0,0,1,0,1,2'b00,0,2'b00,2'b00,2'b00,0,0,2'b00);
        EXR   = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b10,2'b00,1,0,2'b00);
        WBR   = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,0,1,2'b01);
        BEQ   = cw(1,0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,1,0,2'b00);
        BNE   = cw(0,1,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,1,0,2'b00);
        JMP   = cw(0,0,1,0,0,0,2'b00,0,2'b10,2'b00,2'b00,0,0,2'b00);
        JRC   = cw(0,0,1,0,0,0,2'b00,0,2'b11,2'b00,2'b00,0,0,2'b00);
        JALC  = cw(0,0,1,0,0,0,2'b10,0,2'b10,2'b00,2'b00,0,1,2'b10);
        EXI   = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b10,1,0,2'b00);
        WBI   = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,0,1,2'b00);
        ZERO  = '0;

        // R-type add
        add(6'h00, 6'h20, 1, 4'd0,  F_RDY, 0, 2'b00, 0);
        add(6'h00, 6'h20, 1, 4'd1,  DEC,   0, 2'b00, 0);
        add(6'h00, 6'h20, 1, 4'd6,  EXR,   0, 2'b00, 0);
        add(6'h00, 6'h20, 1, 4'd7,  WBR,   0, 2'b00, 0);
        // lw with three wait cycles
        add(6'h23, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 1);
        add(6'h23, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 1);
        add(6'h23, 6'h00, 1, 4'd2,  MADR,  0, 2'b00, 1);
        add(6'h23, 6'h00, 0, 4'd3,  MRD,   0, 2'b00, 1);
        add(6'h23, 6'h00, 0, 4'd3,  MRD,   0, 2'b00, 1);
        add(6'h23, 6'h00, 0, 4'd3,  MRD,   0, 2'b00, 1);
        add(6'h23, 6'h00, 1, 4'd3,  MRD,   0, 2'b00, 1);
        add(6'h23, 6'h00, 1, 4'd4,  WBL,   0, 2'b00, 1);
        // beq then bne
        add(6'h04, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 2);
        add(6'h04, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 2);
        add(6'h04, 6'h00, 1, 4'd8,  BEQ,   0, 2'b00, 2);
        add(6'h05, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 3);
        add(6'h05, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 3);
        add(6'h05, 6'h00, 1, 4'd8,  BNE,   0, 2'b00, 3);
        // sw with one wait cycle
        add(6'h2b, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 4);
        add(6'h2b, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 4);
        add(6'h2b, 6'h00, 1, 4'd2,  MADR,  0, 2'b00, 4);
        add(6'h2b, 6'h00, 0, 4'd5,  MWR,   0, 2'b00, 4);
        add(6'h2b, 6'h00, 1, 4'd5,  MWR,   0, 2'b00, 4);
        // j, jal, jr
        add(6'h02, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 5);
        add(6'h02, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 5);
        add(6'h02, 6'h00, 1, 4'd9,  JMP,   0, 2'b00, 5);
        add(6'h03, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 6);
        add(6'h03, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 6);
        add(6'h03, 6'h00, 1, 4'd11, JALC,  0, 2'b00, 6);
        add(6'h00, 6'h08, 1, 4'd0,  F_RDY, 0, 2'b00, 7);
        add(6'h00, 6'h08, 1, 4'd1,  DEC,   0, 2'b00, 7);
        add(6'h00, 6'h08, 1, 4'd10, JRC,   0, 2'b00, 7);
        // addi
        add(6'h08, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 8);
        add(6'h08, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 8);
        add(6'h08, 6'h00, 1, 4'd12, EXI,   0, 2'b00, 8);
        add(6'h08, 6'h00, 1, 4'd13, WBI,   0, 2'b00, 8);
        // illegal opcode after one fetch wait cycle
        add(6'h3f, 6'h00, 0, 4'd0,  F_NR,  0, 2'b00, 9);
        add(6'h3f, 6'h00, 1, 4'd0,  F_RDY, 0, 2'b00, 9);
        add(6'h3f, 6'h00, 1, 4'd1,  DEC,   0, 2'b00, 9);
        add(6'h3f, 6'h00, 1, 4'd14, ZERO,  1, 2'b01, 9);
        add(6'h3f, 6'h00, 1, 4'd14, ZERO,  1, 2'b01, 9);

        rst = 1'b1; op = '0; funct = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk("reset_state", {state_o, ctl, exc, exc_cause, retired}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        foreach (vecs[i]) begin
            op = vecs[i].op; funct = vecs[i].fn; mem_ready = vecs[i].rdy;
            #2 chk($sformatf("vec%0d", i), {state_o, ctl, exc, exc_cause, retired},
                   {vecs[i].st, vecs[i].ctl, vecs[i].exc, vecs[i].cause, vecs[i].ret});
            @(posedge clk); #1;
        end

        // EXC is sticky until reset; reset clears it asynchronously
        repeat (3) @(posedge clk);
        #1 chk("exc_sticky", {state_o, exc, exc_cause, ctl}, {4'd14, 1'b1, 2'b01, 19'd0});
        rst = 1'b1;
        #2 chk("exc_rst", {state_o, exc, exc_cause, retired, ctl}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // fetch timeout: EXC 16 cycles after entering FETCH
        op = 6'h00; funct = 6'h20; mem_ready = 1'b0;
        cyc = 0;
        while (state_o != 4'd14 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout_cycles", cyc, 16);
        chk("timeout_exc", {exc, exc_cause, ctl, retired}, {1'b1, 2'b10, 19'd0, 32'd0});
        repeat (100 - cyc) @(posedge clk);
        #1 chk("no_timeout_dis", {d2_state, d2_exc, d2_cause, d2_irw}, {4'd0, 1'b0, 2'b00, 1'b0});
        chk("timeout_cause_held", exc_cause, 2'b10);

        // completion on the very cycle the counter reaches its maximum
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 mem_ready = 1'b1;
        #1 chk("edge_ready_fetch", {state_o, ir_wr, pc_wr}, {4'd0, 1'b1, 1'b1});
        @(posedge clk);
        #1 chk("edge_ready_decode", {state_o, exc, exc_cause}, {4'd1, 1'b0, 2'b00});

        // asynchronous reset in the middle of MEM_WRITE
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        op = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 chk("mem_write_active", {state_o, mem_wr, iord}, {4'd5, 1'b1, 1'b1});
        #2 rst = 1'b1;
        #1 chk("rst_mid_write", {state_o, mem_wr, ctl, retired}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle MIPS control unit. Successor to the current fixed Controller.
- Adds a memory wait-state handshake (mem_ready) and a bounded memory-timeout exception.
- Adds bne, jal, jr and addi, plus a retired-instruction counter.
- Drives the existing multicycle datapath muxes, PC write logic, IR, regfile and memory enables; MemtoReg and RegDst widen to 2 bits for jal.

Parameters:
- TIMEOUT_W, 4: width of the wait counter; timeout fires at count 2^TIMEOUT_W-1.
- TIMEOUT_EN, 1: 1 enables the memory-timeout exception; 0 waits forever.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous reset, active-high.
- op in 6: inst[31:26].
- funct in 6: inst[5:0].
- mem_ready in 1: memory completes the current read/write this cycle.
- pc_wr_cond out 1: beq conditional PC write.
- pc_wr_cond_ne out 1: bne conditional PC write (datapath ANDs with ~alu_zero).
- pc_wr out 1: unconditional PC write.
- iord out 1: memory address select, 0=PC, 1=ALUOut.
- mem_rd out 1: memory read enable.
- mem_wr out 1: memory write enable.
- mem_to_reg out 2: write-back data select, 00=ALUOut, 01=MDR, 10=PC.
- ir_wr out 1: IR load enable.
- pc_src out 2: PC source, 00=ALU, 01=ALUOut, 10=jump target, 11=A register.
- alu_op out 2: ALU operation class, 00=add, 01=sub, 10=funct.
- alu_src_b out 2: ALU B select, 00=B, 01=4, 10=sext, 11=sext<<2.
- alu_src_a out 1: ALU A select, 0=PC, 1=A.
- reg_wr out 1: regfile write enable.
- reg_dst out 2: destination register select, 00=rt, 01=rd, 10=r31.
- exc out 1: sticky exception flag.
- exc_cause out 2: 00=none, 01=illegal opcode, 10=memory timeout.
- state_o out 4: current state, for debug.
- retired out CNT_W: retired-instruction count.

Behaviour:
- Reset
  - rst high sets state=FETCH, wait_cnt=0, retired=0, exc=0, exc_cause=00.
  - While rst is high, all control outputs are forced to 0.
- State encoding
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, WB_LOAD=4, MEM_WRITE=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, JR=10, JAL=11, EXEC_I=12, WB_I=13, EXC=14.
  - Any other encoding goes to EXC with cause 01.
- Outputs: any control not listed for a state is 0.
- FETCH
  - Outputs: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_wr=1, pc_wr=1, pc_src=00 are asserted only in the cycle mem_ready=1 (Mealy).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by op:
    - 000000 with funct 001000 -> JR.
    - 000000 otherwise -> EXEC_R.
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
    - 000100 (beq) or 000101 (bne) -> BRANCH.
    - 000010 (j) -> JUMP.
    - 000011 (jal) -> JAL.
    - 001000 (addi) -> EXEC_I.
    - Anything else -> EXC, cause 01.
- MEM_ADDR
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ
  - Outputs: mem_rd=1, iord=1.
  - Holds until mem_ready=1, then goes to WB_LOAD.
- WB_LOAD
  - Outputs: reg_wr=1, mem_to_reg=01, reg_dst=00.
  - Next state: FETCH.
- MEM_WRITE
  - Outputs: mem_wr=1, iord=1.
  - Holds until mem_ready=1, then goes to FETCH.
- EXEC_R
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: WB_R.
- WB_R
  - Outputs: reg_wr=1, reg_dst=01, mem_to_reg=00.
  - Next state: FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_wr_cond=1 if op=000100; pc_wr_cond_ne=1 if op=000101.
  - Next state: FETCH.
- JUMP
  - Outputs: pc_wr=1, pc_src=10.
  - Next state: FETCH.
- JR
  - Outputs: pc_wr=1, pc_src=11.
  - Next state: FETCH.
- JAL
  - Outputs: reg_wr=1, reg_dst=10, mem_to_reg=10, pc_wr=1, pc_src=10.
  - The regfile captures the already-incremented PC before the PC update takes effect.
  - Next state: FETCH.
- EXEC_I
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: WB_I.
- WB_I
  - Outputs: reg_wr=1, reg_dst=00, mem_to_reg=00.
  - Next state: FETCH.
- EXC
  - All controls 0, exc=1.
  - Stays in EXC until rst; exc_cause holds the first cause recorded.
- Wait counter (FETCH, MEM_READ, MEM_WRITE)
  - wait_cnt is 0 on the first cycle in the state and increments each cycle mem_ready=0.
  - It clears on mem_ready=1 and whenever the state is not a wait state.
  - If TIMEOUT_EN=1, mem_ready=0 and wait_cnt=2^TIMEOUT_W-1, the next state is EXC with cause 10.
  - With defaults, EXC is reached 16 cycles after entering the wait state.
  - mem_ready=1 on the same cycle wait_cnt hits max counts as completion; no exception.
- Retired counter
  - Increments by 1 on every transition into FETCH from a non-FETCH state; wraps modulo 2^CNT_W.
  - It does not increment on the exit from reset or on entry to EXC.

Test Plan:
- R-type add (op=0, funct=100000), mem_ready=1 -> states 0,1,6,7,0; reg_wr=1, reg_dst=01 in WB_R; retired=1.
- lw with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held for 4 cycles with mem_rd=1, iord=1; then WB_LOAD with mem_to_reg=01; retired=1.
- beq then bne -> BRANCH asserts pc_wr_cond=1 for beq only and pc_wr_cond_ne=1 for bne only; pc_src=01 in both.
- jal -> JAL state has reg_dst=10, mem_to_reg=10, pc_wr=1, pc_src=10; jr (funct 001000) -> pc_src=11, pc_wr=1.
- op=111111 -> DECODE goes to EXC; exc=1, exc_cause=01, all controls 0; stays in EXC until rst pulsed, then state=0, retired=0.
- Timeout: mem_ready held 0 in FETCH -> EXC after 16 cycles with cause 10. TIMEOUT_EN=0 -> no exception after 100 cycles. rst asserted mid-MEM_WRITE -> immediate FETCH, mem_wr=0.
